// File: rtl/fork_join_pkg.sv
// Shared types and default sizing for the fork/join scheduler.
package fork_join_pkg;

  // Default sizing: NBR supports 1..16 branches.
  localparam int DEF_NBR = 4;
  localparam int DEF_DW  = 8;
  localparam int DEF_CW  = 16;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    JOIN = 2'd2
  } state_t;

endpackage

// File: rtl/fj_branch.sv
// One fork branch: holds its latched enable and delay, remembers whether it
// has fired in the current fork, and emits a registered one-cycle fire pulse
// when the shared elapsed counter reaches its delay.
module fj_branch
  import fork_join_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,      // launch or re-arm: capture config, clear fired
  input  logic          active,    // scheduler in RUN and not being aborted
  input  logic          en_in,
  input  logic [DW-1:0] delay_in,
  input  logic [DW-1:0] elapsed,
  output logic          fire,
  output logic          done       // disabled, already fired, or firing now
);

  logic          en_q;
  logic [DW-1:0] delay_q;
  logic          fired_q;
  logic          hit;

  assign hit  = active && en_q && !fired_q && (elapsed == delay_q);
  assign done = !en_q || fired_q || hit;

  // Capture config on load; the fire pulse is the registered match.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      delay_q <= '0;
      fired_q <= 1'b0;
      fire    <= 1'b0;
    end else begin
      fire <= hit;
      if (load) begin
        en_q    <= en_in;
        delay_q <= delay_in;
        fired_q <= 1'b0;
      end else if (hit) begin
        fired_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fork_join_sched.sv
// Fork/join scheduler: launches NBR timed branches, emits a join pulse once
// every enabled branch has fired, and optionally re-arms after each join.
//
// Control contract: start is a level request honoured only in IDLE (ignored
// while busy); abort wins over everything except reset; join_done and fire
// are single-cycle registered pulses with no combinational input paths, so a
// consumer must take them in the cycle they are high (no backpressure).
module fork_join_sched
  import fork_join_pkg::*;
#(
  parameter int NBR = DEF_NBR,
  parameter int DW  = DEF_DW,
  parameter int CW  = DEF_CW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              auto_rearm,
  input  logic [NBR-1:0]    en_mask,
  input  logic [NBR*DW-1:0] delay_i,
  output logic              busy,
  output logic [NBR-1:0]    fire,
  output logic              join_done,
  output logic [CW-1:0]     iter_cnt,
  output state_t            state_dbg
);

  localparam logic [DW-1:0] ELAPSED_MAX = {DW{1'b1}};

  state_t          state_q;
  state_t          state_d;
  logic [DW-1:0]   elapsed_q;
  logic [NBR-1:0]  done;
  logic            all_done;
  logic            active;
  logic            load;
  logic            join_now;

  // Branches are only allowed to match while running and not being aborted.
  assign active   = (state_q == RUN) && !abort;
  assign load     = !abort && (((state_q == IDLE) && start) ||
                               ((state_q == JOIN) && auto_rearm));
  assign join_now = (state_q == JOIN) && !abort;
  assign all_done = &done;

  for (genvar i = 0; i < NBR; i++) begin : g_branch
    fj_branch #(.DW(DW)) u_branch (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .active   (active),
      .en_in    (en_mask[i]),
      .delay_in (delay_i[i*DW +: DW]),
      .elapsed  (elapsed_q),
      .fire     (fire[i]),
      .done     (done[i])
    );
  end

  // Next-state logic; abort returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (all_done) state_d = JOIN;
        JOIN:    state_d = auto_rearm ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, saturating elapsed counter, join pulse and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
      join_done <= 1'b0;
      iter_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      join_done <= join_now;
      if (join_now) iter_cnt <= iter_cnt + CW'(1);
      if (load) begin
        elapsed_q <= '0;
      end else if ((state_q == RUN) && (elapsed_q != ELAPSED_MAX)) begin
        elapsed_q <= elapsed_q + DW'(1);
      end
    end
  end

  assign busy      = (state_q == RUN) || (state_q == JOIN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fork_join_sched.sv
// Self-checking bench for fork_join_sched. A timeline model predicts, from
// each launch edge and the latched delays, exactly when every output pulses.
module tb_fork_join_sched;
  import fork_join_pkg::*;

  localparam int NBR = 4;
  localparam int DW  = 8;
  localparam int CW  = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic              auto_rearm;
  logic [NBR-1:0]    en_mask;
  logic [NBR*DW-1:0] delay_i;
  logic              busy;
  logic [NBR-1:0]    fire;
  logic              join_done;
  logic [CW-1:0]     iter_cnt;
  state_t            state_dbg;

  fork_join_sched #(.NBR(NBR), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .auto_rearm (auto_rearm),
    .en_mask    (en_mask),
    .delay_i    (delay_i),
    .busy       (busy),
    .fire       (fire),
    .join_done  (join_done),
    .iter_cnt   (iter_cnt),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard counters and expected join-count queue.
  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Timeline reference model: a launch at edge L makes branch i fire in the
  // cycle after edge L+1+d_i, joins in the cycle after edge L+2+dmax, and is
  // busy from L up to (not including) the join edge.
  int            cyc = 0;
  int            m_l = 0;
  bit            m_active = 1'b0;
  logic [NBR-1:0] m_mask = '0;
  int            m_d[NBR];
  int            m_dmax = 0;
  logic [CW-1:0] m_iter = '0;
  bit            m_join;
  logic [NBR-1:0] e_fire;
  state_t        e_state;
  logic [CW-1:0] popped;

  task automatic model_launch();
    m_l      = cyc;
    m_mask   = en_mask;
    m_dmax   = 0;
    for (int i = 0; i < NBR; i++) begin
      m_d[i] = int'(delay_i[i*DW +: DW]);
      if (m_mask[i] && m_d[i] > m_dmax) m_dmax = m_d[i];
    end
    m_active = 1'b1;
  endtask

  // Monitor: advance the model on each edge, compare outputs 1 time unit later.
  always @(posedge clk) begin
    cyc++;
    m_join = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      m_iter   = '0;
      exp_q.delete();
    end else if (abort) begin
      m_active = 1'b0;
    end else if (m_active && (cyc - m_l) == 2 + m_dmax) begin
      m_join = 1'b1;
      m_iter = m_iter + 1'b1;
      exp_q.push_back(m_iter);
      if (auto_rearm) model_launch();
      else m_active = 1'b0;
    end else if (!m_active && start) begin
      model_launch();
    end
    #1;
    for (int i = 0; i < NBR; i++)
      e_fire[i] = m_active && m_mask[i] && ((cyc - m_l) == 1 + m_d[i]);
    if (!m_active) e_state = IDLE;
    else if ((cyc - m_l) == 1 + m_dmax) e_state = JOIN;
    else e_state = RUN;
    check_eq("fire", 32'(fire), 32'(e_fire));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("join_done", 32'(join_done), 32'(m_join));
    check_eq("iter_cnt", 32'(iter_cnt), 32'(m_iter));
    check_eq("state", 32'(state_dbg), 32'(e_state));
    if (join_done) begin
      if (exp_q.size() == 0) begin
        check_eq("join_unexpected", 32'(join_done), 32'(0));
      end else begin
        popped = exp_q.pop_front();
        check_eq("join_iter", 32'(iter_cnt), 32'(popped));
      end
    end
  end

  // Driver tasks: inputs change on the falling edge.
  task automatic launch(input logic [NBR-1:0] m, input logic [NBR*DW-1:0] d, input logic a);
    @(negedge clk);
    en_mask    = m;
    delay_i    = d;
    auto_rearm = a;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(busy), 32'(0));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [CW-1:0] target;
  logic [CW-1:0] iter_before;
  int            n;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    auto_rearm = 1'b0;
    en_mask    = '0;
    delay_i    = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_iter", 32'(iter_cnt), 32'(0));
    check_eq("reset_busy", 32'(busy), 32'(0));
    reset = 1'b0;

    // Two branches, d=(5,10), single shot.
    launch(4'b0011, {8'd0, 8'd0, 8'd10, 8'd5}, 1'b0);
    wait_idle("single_idle", 40);
    check_eq("single_iter", 32'(iter_cnt), 32'(1));

    // Same config with auto re-arm for five joins.
    do_reset(2);
    target = m_iter + 16'd5;
    launch(4'b0011, {8'd0, 8'd0, 8'd10, 8'd5}, 1'b1);
    n = 0;
    while (iter_cnt != target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("auto_five", 32'(iter_cnt), 32'(5));
    auto_rearm = 1'b0;
    wait_idle("auto_idle", 40);

    // Shared delays, a disabled zero-delay branch.
    launch(4'b1011, {8'd7, 8'd0, 8'd3, 8'd3}, 1'b0);
    wait_idle("mixed_idle", 40);

    // Empty mask: RUN one cycle, JOIN one cycle.
    iter_before = m_iter;
    launch(4'b0000, {8'd9, 8'd9, 8'd9, 8'd9}, 1'b0);
    wait_idle("mask0_idle", 10);
    check_eq("mask0_iter", 32'(iter_cnt), 32'(iter_before + 16'd1));

    // Abort during the fork, then a clean relaunch.
    iter_before = m_iter;
    launch(4'b0011, {8'd0, 8'd0, 8'd10, 8'd5}, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'(0));
    check_eq("abort_iter", 32'(iter_cnt), 32'(iter_before));
    launch(4'b0011, {8'd0, 8'd0, 8'd10, 8'd5}, 1'b0);
    wait_idle("relaunch_idle", 40);

    // Reset mid-run, then start pulses and config churn while busy.
    launch(4'b0011, {8'd0, 8'd0, 8'd10, 8'd5}, 1'b0);
    repeat (3) @(negedge clk);
    do_reset(1);
    check_eq("midreset_iter", 32'(iter_cnt), 32'(0));
    launch(4'b1111, {8'd4, 8'd2, 8'd6, 8'd1}, 1'b0);
    @(negedge clk);
    en_mask = 4'b0001;
    delay_i = {8'd20, 8'd20, 8'd20, 8'd20};
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_idle("busy_start_idle", 40);

    // Saturation boundary: largest delay alongside a zero delay.
    launch(4'b0011, {8'd0, 8'd0, 8'd0, 8'd255}, 1'b0);
    wait_idle("sat_idle", 300);

    // Randomised launches with churn, occasional aborts and re-arms.
    for (int t = 0; t < 25; t++) begin
      launch(4'($urandom_range(0, 15)),
             {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
              8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))},
             ($urandom_range(0, 3) == 0));
      n = 0;
      while (busy && n < 400) begin
        @(negedge clk);
        n++;
        start   = ($urandom_range(0, 3) == 0);
        delay_i = $urandom;
        en_mask = 4'($urandom);
        abort   = ($urandom_range(0, 59) == 0);
        if (n > 30) auto_rearm = 1'b0;
      end
      start = 1'b0;
      abort = 1'b0;
      check_eq("rand_idle", 32'(busy), 32'(0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_eq("join_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
